booth_seq_multiplier: RTL and testbench

BOOTH_SEQ_MULTIPLIER -- requirements
Module: booth_seq_multiplier

---
 rtl/mult_pkg.sv | 6 +
 rtl/n_bit_adder.sv | 12 +
 rtl/booth_seq_multiplier.sv | 82 ++++++++
 tb/tb_booth_seq_multiplier.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// mult_pkg: shared types and defaults for the sequential Booth multiplier
package mult_pkg;
    localparam int DEFAULT_WIDTH = 8;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    typedef enum logic [1:0] {NOP, ADD, SUB} booth_op_t;
endpackage

// File: rtl/n_bit_adder.sv
// n_bit_adder: N-bit adder with carry in and carry out
module n_bit_adder #(
    parameter int N = 9
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    output logic [N-1:0] Sum,
    output logic         Cout
);
    assign {Cout, Sum} = {1'b0, A} + {1'b0, B} + (N+1)'(Cin);
endmodule

// File: rtl/booth_seq_multiplier.sv
// booth_seq_multiplier: radix-2 Booth sequential multiplier, signed or unsigned operands
module booth_seq_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH + 2);
    state_t        state;
    booth_op_t     op;
    logic [CW-1:0] cnt;
    logic [WIDTH:0] acc, m, q, addend, sum, sel;
    logic          q_1, unused_cout;

    // recode the current multiplier bit pair and pick the accumulator update
    always_comb begin
        case ({q[0], q_1})
            2'b10:   op = SUB;
            2'b01:   op = ADD;
            default: op = NOP;
        endcase
        addend = op == SUB ? ~m : m;
        sel = op == NOP ? acc : sum;
    end

    n_bit_adder #(.N(WIDTH + 1)) u_add (
        .A(acc),
        .B(addend),
        .Cin(op == SUB),
        .Sum(sum),
        .Cout(unused_cout)
    );

    // FSM, shift datapath and registered status/product outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            acc <= '0;
            m <= '0;
            q <= '0;
            q_1 <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            product <= '0;
        end else begin
            busy <= state == CALC;
            done <= state == DONE;
            if (state == DONE) product <= {acc[WIDTH-2:0], q};
            case (state)
                CALC: begin
                    acc <= {sel[WIDTH], sel[WIDTH:1]};
                    q <= {sel[0], q[WIDTH:1]};
                    q_1 <= q[0];
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH)) state <= DONE;
                end
                default: begin
                    if (start) begin
                        m <= {signed_mode & A[WIDTH-1], A};
                        q <= {signed_mode & B[WIDTH-1], B};
                        acc <= '0;
                        q_1 <= 1'b0;
                        cnt <= '0;
                        state <= CALC;
                    end else if (state == DONE) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_booth_seq_multiplier.sv
// tb_booth_seq_multiplier: self-checking bench for four widths of the Booth multiplier
module tb_booth_seq_multiplier;
    typedef struct {
        int          idx;
        logic        sm;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sm_in = 1'b0;
    logic [31:0] a_in = '0, b_in = '0;
    logic [3:0]  start_v = '0, busy_v, done_v, done_q = '0;
    logic [7:0]  p4;
    logic [15:0] p8;
    logic [31:0] p16;
    logic [63:0] p32;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    booth_seq_multiplier #(.WIDTH(4)) u4 (.clk(clk), .rst(rst), .start(start_v[0]), .signed_mode(sm_in),
        .A(a_in[3:0]), .B(b_in[3:0]), .busy(busy_v[0]), .done(done_v[0]), .product(p4));
    booth_seq_multiplier #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .start(start_v[1]), .signed_mode(sm_in),
        .A(a_in[7:0]), .B(b_in[7:0]), .busy(busy_v[1]), .done(done_v[1]), .product(p8));
    booth_seq_multiplier #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .start(start_v[2]), .signed_mode(sm_in),
        .A(a_in[15:0]), .B(b_in[15:0]), .busy(busy_v[2]), .done(done_v[2]), .product(p16));
    booth_seq_multiplier #(.WIDTH(32)) u32 (.clk(clk), .rst(rst), .start(start_v[3]), .signed_mode(sm_in),
        .A(a_in), .B(b_in), .busy(busy_v[3]), .done(done_v[3]), .product(p32));

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++)
            if (done_v[i] && done_q[i]) begin
                errors++;
                $display("FAIL done_pulse dut%0d: done high 2 cycles, required 1", i);
            end
        done_q = done_v;
    end

    function automatic logic [63:0] get_prod(input int idx);
        case (idx)
            0: return 64'(p4);
            1: return 64'(p8);
            2: return 64'(p16);
            default: return p32;
        endcase
    endfunction

    function automatic logic [31:0] wmask(input int n);
        return n == 32 ? 32'hFFFF_FFFF : 32'((64'd1 << n) - 1);
    endfunction

    function automatic logic [63:0] model(input int n, input logic sm, input logic [31:0] a, input logic [31:0] b);
        longint x = longint'(a), y = longint'(b);
        logic [63:0] mask = n == 32 ? '1 : (64'd1 << (2 * n)) - 1;
        if (sm && a[n-1]) x -= longint'(1) << n;
        if (sm && b[n-1]) y -= longint'(1) << n;
        return 64'(x * y) & mask;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic run_op(input int idx, input logic sm, input logic [31:0] a, input logic [31:0] b,
                          output logic [63:0] p, output int lat, output int bcnt);
        sm_in = sm;
        a_in = a;
        b_in = b;
        start_v[idx] = 1'b1;
        @(negedge clk);
        start_v[idx] = 1'b0;
        a_in = $urandom;
        b_in = $urandom;
        sm_in = 1'($urandom);
        lat = 0;
        bcnt = 0;
        while (!done_v[idx] && lat < 200) begin
            bcnt += int'(busy_v[idx]);
            @(negedge clk);
            lat++;
        end
        p = get_prod(idx);
    endtask

    task automatic rand_op(input int idx);
        int n = 4 << idx, lat, bc;
        logic [31:0] mk = wmask(n), a, b;
        logic [63:0] p;
        logic sm = 1'($urandom);
        a = $urandom & mk;
        b = $urandom & mk;
        case ($urandom_range(0, 9))
            0: a = 0;
            1: a = mk;
            2: a = 32'd1 << (n - 1);
            default: ;
        endcase
        case ($urandom_range(0, 9))
            0: b = 0;
            1: b = mk;
            2: b = 32'd1 << (n - 1);
            default: ;
        endcase
        run_op(idx, sm, a, b, p, lat, bc);
        check($sformatf("rand_w%0d s%0d %0h*%0h", n, sm, a, b), p, model(n, sm, a, b));
        check($sformatf("rand_w%0d_latency", n), 64'(lat), 64'(n + 2));
    endtask

    initial begin
        vec_t tbl[12];
        logic [63:0] p;
        int lat, bc, n;
        tbl[0]  = '{1, 1'b1, 32'h80, 32'h80, 64'h4000};
        tbl[1]  = '{1, 1'b1, 32'hFF, 32'h01, 64'hFFFF};
        tbl[2]  = '{1, 1'b0, 32'hFF, 32'h01, 64'h00FF};
        tbl[3]  = '{1, 1'b0, 32'hFF, 32'hFF, 64'hFE01};
        tbl[4]  = '{1, 1'b1, 32'h7F, 32'h80, 64'hC080};
        tbl[5]  = '{1, 1'b0, 32'h00, 32'h00, 64'h0000};
        tbl[6]  = '{1, 1'b1, 32'hFF, 32'hFF, 64'h0001};
        tbl[7]  = '{0, 1'b1, 32'h8, 32'h8, 64'h40};
        tbl[8]  = '{0, 1'b1, 32'h8, 32'h7, 64'hC8};
        tbl[9]  = '{2, 1'b1, 32'h8000, 32'h8000, 64'h4000_0000};
        tbl[10] = '{3, 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
        tbl[11] = '{3, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};

        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("reset_busy dut%0d", i), 64'(busy_v[i]), 64'd0);
            check($sformatf("reset_done dut%0d", i), 64'(done_v[i]), 64'd0);
            check($sformatf("reset_product dut%0d", i), get_prod(i), 64'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            n = 4 << tbl[i].idx;
            run_op(tbl[i].idx, tbl[i].sm, tbl[i].a, tbl[i].b, p, lat, bc);
            check($sformatf("vec%0d_product", i), p, tbl[i].exp);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(n + 2));
            check($sformatf("vec%0d_busy_cycles", i), 64'(bc), 64'(n + 1));
        end

        for (int s = 0; s < 2; s++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++) begin
                    run_op(0, 1'(s), 32'(a), 32'(b), p, lat, bc);
                    check($sformatf("w4 s%0d %0d*%0d", s, a, b), p, model(4, 1'(s), 32'(a), 32'(b)));
                end

        sm_in = 1'b0;
        a_in = 32'hFF;
        b_in = 32'hFF;
        start_v[1] = 1'b1;
        @(negedge clk);
        a_in = 32'h12;
        b_in = 32'h34;
        n = 0;
        while (!done_v[1] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("b2b_first_product", get_prod(1), 64'hFE01);
        check("b2b_first_latency", 64'(n), 64'd10);
        start_v[1] = 1'b0;
        @(negedge clk);
        n = 1;
        while (!done_v[1] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("b2b_second_product", get_prod(1), 64'h03A8);
        check("b2b_done_gap", 64'(n), 64'd10);

        a_in = 32'd3;
        b_in = 32'd5;
        start_v[1] = 1'b1;
        @(negedge clk);
        start_v[1] = 1'b0;
        repeat (2) @(negedge clk);
        a_in = 32'd7;
        b_in = 32'd7;
        start_v[1] = 1'b1;
        @(negedge clk);
        start_v[1] = 1'b0;
        n = 3;
        while (!done_v[1] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("busy_start_product", get_prod(1), 64'd15);
        check("busy_start_latency", 64'(n), 64'd10);
        n = 0;
        repeat (15) begin
            @(negedge clk);
            n += int'(done_v[1]);
        end
        check("busy_start_extra_done", 64'(n), 64'd0);

        a_in = 32'd9;
        b_in = 32'd9;
        start_v[1] = 1'b1;
        @(negedge clk);
        start_v[1] = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 64'(busy_v[1]), 64'd0);
        check("abort_product", get_prod(1), 64'd0);
        n = 0;
        repeat (15) begin
            @(negedge clk);
            n += int'(done_v[1]);
        end
        check("abort_no_done", 64'(n), 64'd0);
        check("abort_product_held", get_prod(1), 64'd0);

        rst = 1'b1;
        start_v[1] = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start_v[1] = 1'b0;
        @(negedge clk);
        check("rst_priority_busy", 64'(busy_v[1]), 64'd0);
        @(negedge clk);
        check("rst_priority_busy_late", 64'(busy_v[1]), 64'd0);

        for (int i = 0; i < 1000; i++) rand_op(2);
        for (int i = 0; i < 600; i++) rand_op(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
